arbitro_banco_registradores: RTL and testbench

ARBITRO_BANCO_REGISTRADORES -- requirements
Module: arbitro_banco_registradores

---
 rtl/arbitro_banco_registradores_pkg.sv | 28 ++
 rtl/arbitro_banco_registradores_rr2.sv | 37 +++
 rtl/arbitro_banco_registradores.sv | 126 ++++++++++++
 tb/tb_arbitro_banco_registradores.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_banco_registradores_pkg.sv
// Shared widths, FSM state encoding and captured-request record for the
// register-bank arbiter.
package arbitro_banco_registradores_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int DROP_W = 8;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE      = 2'd1,
      READ_ISSUE = 2'd2,
      READ_RESP  = 2'd3
   } estado_t;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr_a;
      logic [ADDR_W-1:0] addr_b;
      logic [DATA_W-1:0] data;
      logic              owner;
   } pedido_t;

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] valor);
      return (&valor) ? valor : valor + 1'b1;
   endfunction

endpackage

// File: rtl/arbitro_banco_registradores_rr2.sv
// Two-way grant logic: round-robin with a pointer, or fixed priority to
// requester 0 when FIXED_PRIORITY is set.
module arbitro_rr2 #(
   parameter int FIXED_PRIORITY = 0
) (
   input  logic       Clock_in,
   input  logic       Signal_reset,
   input  logic [1:0] valids,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       pointer
);

   always_comb begin
      grant = 2'b00;
      if (FIXED_PRIORITY != 0) begin
         if (valids[0])      grant = 2'b01;
         else if (valids[1]) grant = 2'b10;
      end else begin
         case (valids)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pointer ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   // After a grant the pointer favours whoever lost.
   always_ff @(posedge Clock_in or posedge Signal_reset) begin
      if (Signal_reset)
         pointer <= 1'b0;
      else if (advance && (|grant))
         pointer <= grant[0];
   end

endmodule

// File: rtl/arbitro_banco_registradores.sv
// Arbitrates two requesters onto a single register bank with one write port
// and two registered read ports.
module arbitro_banco_registradores
   import arbitro_banco_registradores_pkg::*;
#(
   parameter int PROTECT_R0     = 1,
   parameter int FIXED_PRIORITY = 0
) (
   input  logic              Clock_in,
   input  logic              Signal_reset,
   input  logic              Req_valid_0,
   input  logic              Req_valid_1,
   input  logic              Req_write_0,
   input  logic              Req_write_1,
   input  logic [ADDR_W-1:0] Req_addr_a_0,
   input  logic [ADDR_W-1:0] Req_addr_a_1,
   input  logic [ADDR_W-1:0] Req_addr_b_0,
   input  logic [ADDR_W-1:0] Req_addr_b_1,
   input  logic [DATA_W-1:0] Req_data_0,
   input  logic [DATA_W-1:0] Req_data_1,
   output logic              Req_ready_0,
   output logic              Req_ready_1,
   output logic              Rsp_valid_0,
   output logic              Rsp_valid_1,
   output logic [DATA_W-1:0] Rsp_data_1,
   output logic [DATA_W-1:0] Rsp_data_2,
   output logic [ADDR_W-1:0] Bank_read_1,
   output logic [ADDR_W-1:0] Bank_read_2,
   output logic [ADDR_W-1:0] Bank_address_to_write,
   output logic [DATA_W-1:0] Bank_data_to_write,
   output logic              Bank_signal_write,
   input  logic [DATA_W-1:0] Bank_out_1,
   input  logic [DATA_W-1:0] Bank_out_2,
   output logic              Busy,
   output logic [DROP_W-1:0] Drop_count
);

   // state      | meaning
   // IDLE       | waiting; grants one requester and captures its request
   // WRITE      | one-cycle write strobe (suppressed for protected r0)
   // READ_ISSUE | read addresses presented to the bank
   // READ_RESP  | bank outputs forwarded with the owner's Rsp_valid pulse

   estado_t    estado, estado_prox;
   pedido_t    pedido, pedido_sel;
   logic [1:0] valids, grant;
   logic       ptr_rr, aceita, owner_sel, descarta;

   assign valids = {Req_valid_1, Req_valid_0};
   assign aceita = (estado == IDLE) && (|grant);

   arbitro_rr2 #(
      .FIXED_PRIORITY(FIXED_PRIORITY)
   ) u_rr2 (
      .Clock_in    (Clock_in),
      .Signal_reset(Signal_reset),
      .valids      (valids),
      .advance     (estado == IDLE),
      .grant       (grant),
      .pointer     (ptr_rr)
   );

   // Under contention in round-robin mode the pointer names the winner.
   assign owner_sel = (valids == 2'b11 && FIXED_PRIORITY == 0) ? ptr_rr : grant[1];

   always_comb begin
      pedido_sel = '0;
      pedido_sel.owner = owner_sel;
      if (owner_sel) begin
         pedido_sel.write  = Req_write_1;
         pedido_sel.addr_a = Req_addr_a_1;
         pedido_sel.addr_b = Req_addr_b_1;
         pedido_sel.data   = Req_data_1;
      end else begin
         pedido_sel.write  = Req_write_0;
         pedido_sel.addr_a = Req_addr_a_0;
         pedido_sel.addr_b = Req_addr_b_0;
         pedido_sel.data   = Req_data_0;
      end
   end

   assign descarta = (PROTECT_R0 != 0) && (pedido.addr_a == '0);

   always_ff @(posedge Clock_in or posedge Signal_reset) begin
      if (Signal_reset) begin
         estado     <= IDLE;
         pedido     <= '0;
         Drop_count <= '0;
      end else begin
         estado <= estado_prox;
         if (aceita)
            pedido <= pedido_sel;
         if (estado == WRITE && descarta)
            Drop_count <= sat_inc(Drop_count);
      end
   end

   always_comb begin
      estado_prox = estado;
      case (estado)
         IDLE:       if (aceita) estado_prox = pedido_sel.write ? WRITE : READ_ISSUE;
         WRITE:      estado_prox = IDLE;
         READ_ISSUE: estado_prox = READ_RESP;
         READ_RESP:  estado_prox = IDLE;
         default:    estado_prox = IDLE;
      endcase
   end

   // Ready is gated by reset so every output is 0 while reset is held.
   assign Req_ready_0 = aceita && grant[0] && !Signal_reset;
   assign Req_ready_1 = aceita && grant[1] && !Signal_reset;

   assign Rsp_valid_0 = (estado == READ_RESP) && !pedido.owner;
   assign Rsp_valid_1 = (estado == READ_RESP) &&  pedido.owner;
   assign Rsp_data_1  = (estado == READ_RESP) ? Bank_out_1 : '0;
   assign Rsp_data_2  = (estado == READ_RESP) ? Bank_out_2 : '0;

   assign Bank_read_1           = pedido.addr_a;
   assign Bank_read_2           = pedido.addr_b;
   assign Bank_address_to_write = pedido.addr_a;
   assign Bank_data_to_write    = pedido.data;
   assign Bank_signal_write     = (estado == WRITE) && !descarta;

   assign Busy = (estado != IDLE);

endmodule

// File: tb/tb_arbitro_banco_registradores.sv
// Directed bench for the register-bank arbiter; a second instance with
// fixed priority runs on the same stimulus for the grant-order check.
module tb_arbitro_banco_registradores;

   logic        Clock_in, Signal_reset;
   logic        Req_valid_0, Req_valid_1, Req_write_0, Req_write_1;
   logic [4:0]  Req_addr_a_0, Req_addr_a_1, Req_addr_b_0, Req_addr_b_1;
   logic [31:0] Req_data_0, Req_data_1;
   logic        Req_ready_0, Req_ready_1, Rsp_valid_0, Rsp_valid_1;
   logic [31:0] Rsp_data_1, Rsp_data_2;
   logic [4:0]  Bank_read_1, Bank_read_2, Bank_address_to_write;
   logic [31:0] Bank_data_to_write;
   logic        Bank_signal_write, Busy;
   logic [31:0] Bank_out_1, Bank_out_2;
   logic [7:0]  Drop_count;

   logic        b_ready_0, b_ready_1, b_rsp_valid_0, b_rsp_valid_1;
   logic [31:0] b_rsp_data_1, b_rsp_data_2, b_data_to_write;
   logic [4:0]  b_read_1, b_read_2, b_addr_to_write;
   logic        b_signal_write, b_busy;
   logic [7:0]  b_drop_count;

   int n_chk = 0;
   int n_fail = 0;
   int n_strobe = 0;
   int n_rsp = 0;

   logic [31:0] mem [32] = '{default: 32'h0};

   arbitro_banco_registradores dut (
      .Clock_in(Clock_in), .Signal_reset(Signal_reset),
      .Req_valid_0(Req_valid_0), .Req_valid_1(Req_valid_1),
      .Req_write_0(Req_write_0), .Req_write_1(Req_write_1),
      .Req_addr_a_0(Req_addr_a_0), .Req_addr_a_1(Req_addr_a_1),
      .Req_addr_b_0(Req_addr_b_0), .Req_addr_b_1(Req_addr_b_1),
      .Req_data_0(Req_data_0), .Req_data_1(Req_data_1),
      .Req_ready_0(Req_ready_0), .Req_ready_1(Req_ready_1),
      .Rsp_valid_0(Rsp_valid_0), .Rsp_valid_1(Rsp_valid_1),
      .Rsp_data_1(Rsp_data_1), .Rsp_data_2(Rsp_data_2),
      .Bank_read_1(Bank_read_1), .Bank_read_2(Bank_read_2),
      .Bank_address_to_write(Bank_address_to_write),
      .Bank_data_to_write(Bank_data_to_write),
      .Bank_signal_write(Bank_signal_write),
      .Bank_out_1(Bank_out_1), .Bank_out_2(Bank_out_2),
      .Busy(Busy), .Drop_count(Drop_count)
   );

   arbitro_banco_registradores #(.FIXED_PRIORITY(1)) dut_fixa (
      .Clock_in(Clock_in), .Signal_reset(Signal_reset),
      .Req_valid_0(Req_valid_0), .Req_valid_1(Req_valid_1),
      .Req_write_0(Req_write_0), .Req_write_1(Req_write_1),
      .Req_addr_a_0(Req_addr_a_0), .Req_addr_a_1(Req_addr_a_1),
      .Req_addr_b_0(Req_addr_b_0), .Req_addr_b_1(Req_addr_b_1),
      .Req_data_0(Req_data_0), .Req_data_1(Req_data_1),
      .Req_ready_0(b_ready_0), .Req_ready_1(b_ready_1),
      .Rsp_valid_0(b_rsp_valid_0), .Rsp_valid_1(b_rsp_valid_1),
      .Rsp_data_1(b_rsp_data_1), .Rsp_data_2(b_rsp_data_2),
      .Bank_read_1(b_read_1), .Bank_read_2(b_read_2),
      .Bank_address_to_write(b_addr_to_write),
      .Bank_data_to_write(b_data_to_write),
      .Bank_signal_write(b_signal_write),
      .Bank_out_1(Bank_out_1), .Bank_out_2(Bank_out_2),
      .Busy(b_busy), .Drop_count(b_drop_count)
   );

   initial Clock_in = 1'b0;
   always #5 Clock_in = ~Clock_in;

   // Register bank model: registered read ports refresh whenever not writing.
   always @(posedge Clock_in) begin
      if (Bank_signal_write) mem[Bank_address_to_write] <= Bank_data_to_write;
      else begin
         Bank_out_1 <= mem[Bank_read_1];
         Bank_out_2 <= mem[Bank_read_2];
      end
   end

   always @(posedge Clock_in) begin
      if (Bank_signal_write === 1'b1) n_strobe++;
      if (Rsp_valid_0 === 1'b1 || Rsp_valid_1 === 1'b1) n_rsp++;
   end

   task automatic step();
      @(posedge Clock_in);
      #1;
   endtask

   task automatic clear_inputs();
      Req_valid_0 = 0; Req_valid_1 = 0; Req_write_0 = 0; Req_write_1 = 0;
      Req_addr_a_0 = 0; Req_addr_a_1 = 0; Req_addr_b_0 = 0; Req_addr_b_1 = 0;
      Req_data_0 = 0; Req_data_1 = 0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      Signal_reset = 1;
      step(); step();
      Signal_reset = 0;
      step();
   endtask

   // Raises one request, waits (bounded) for its ready, lets the edge capture
   // it, then drops valid. Returns in the first cycle after acceptance.
   task automatic issue(input bit who, input logic wr, input logic [4:0] a,
                        input logic [4:0] b, input logic [31:0] d, output int waited);
      if (who) begin
         Req_write_1 = wr; Req_addr_a_1 = a; Req_addr_b_1 = b; Req_data_1 = d; Req_valid_1 = 1;
      end else begin
         Req_write_0 = wr; Req_addr_a_0 = a; Req_addr_b_0 = b; Req_data_0 = d; Req_valid_0 = 1;
      end
      #1;
      waited = 0;
      while (!(who ? Req_ready_1 : Req_ready_0) && waited < 20) begin
         step();
         waited++;
      end
      n_chk++;
      if (waited >= 20) begin
         n_fail++;
         $display("FAIL issue_timeout: requester %0d never saw ready within %0d cycles", who, waited);
      end
      step();
      if (who) Req_valid_1 = 0; else Req_valid_0 = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      Signal_reset = 1;
      Req_valid_0 = 1;
      #2;
      n_chk++;
      if ({Req_ready_0, Req_ready_1, Rsp_valid_0, Rsp_valid_1, Bank_signal_write, Busy} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {Req_ready_0, Req_ready_1, Rsp_valid_0, Rsp_valid_1, Bank_signal_write, Busy});
      end
      n_chk++;
      if ({Bank_read_1, Bank_read_2, Bank_address_to_write, Bank_data_to_write, Drop_count, Rsp_data_1} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got r1=%h r2=%h wa=%h wd=%h drop=%h rsp=%h expected all 0",
                  Bank_read_1, Bank_read_2, Bank_address_to_write, Bank_data_to_write, Drop_count, Rsp_data_1);
      end
      step();
      Signal_reset = 0;
      Req_valid_0 = 0;
      step();
   endtask

   task automatic test_write_read();
      int w, s0;
      apply_reset();
      s0 = n_strobe;
      issue(0, 1, 5'd5, 5'd0, 32'hDEADBEEF, w);
      n_chk++;
      if ({Bank_signal_write, Bank_address_to_write, Bank_data_to_write} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL wr_strobe: got we=%b a=%0d d=%h expected we=1 a=5 d=deadbeef",
                  Bank_signal_write, Bank_address_to_write, Bank_data_to_write);
      end
      step();
      n_chk++;
      if (Busy !== 1'b0) begin n_fail++; $display("FAIL wr_done_busy: got %b expected 0", Busy); end
      issue(0, 0, 5'd5, 5'd0, 32'h0, w);
      n_chk++;
      if ({Rsp_valid_0, Busy, Bank_read_1, Bank_read_2} !== {1'b0, 1'b1, 5'd5, 5'd0}) begin
         n_fail++;
         $display("FAIL rd_issue: got rsp=%b busy=%b r1=%0d r2=%0d expected rsp=0 busy=1 r1=5 r2=0",
                  Rsp_valid_0, Busy, Bank_read_1, Bank_read_2);
      end
      step();
      n_chk++;
      if ({Rsp_valid_0, Rsp_valid_1, Rsp_data_1, Rsp_data_2} !== {1'b1, 1'b0, 32'hDEADBEEF, 32'h0}) begin
         n_fail++;
         $display("FAIL rd_resp: got v0=%b v1=%b d1=%h d2=%h expected v0=1 v1=0 d1=deadbeef d2=0",
                  Rsp_valid_0, Rsp_valid_1, Rsp_data_1, Rsp_data_2);
      end
      step();
      n_chk++;
      if (n_strobe - s0 !== 1) begin
         n_fail++; $display("FAIL wr_strobe_count: got %0d expected 1", n_strobe - s0);
      end
   endtask

   task automatic test_contention();
      int ga[4], gb[4];
      int na, nb, cyc;
      apply_reset();
      na = 0; nb = 0;
      Req_write_0 = 1; Req_addr_a_0 = 5'd7; Req_data_0 = 32'h7;
      Req_write_1 = 1; Req_addr_a_1 = 5'd8; Req_data_1 = 32'h8;
      Req_valid_0 = 1; Req_valid_1 = 1;
      #1;
      for (cyc = 0; cyc < 40 && (na < 4 || nb < 4); cyc++) begin
         if (Req_ready_0 && Req_ready_1) begin
            n_chk++; n_fail++;
            $display("FAIL both_ready: got ready0=1 ready1=1 expected at most one");
         end
         if (na < 4 && (Req_ready_0 || Req_ready_1)) begin ga[na] = Req_ready_1 ? 1 : 0; na++; end
         if (nb < 4 && (b_ready_0 || b_ready_1)) begin gb[nb] = b_ready_1 ? 1 : 0; nb++; end
         step();
      end
      clear_inputs();
      step(); step(); step();
      n_chk++;
      if (na != 4 || ga[0] != 0 || ga[1] != 1 || ga[2] != 0 || ga[3] != 1) begin
         n_fail++;
         $display("FAIL rr_order: got n=%0d %0d,%0d,%0d,%0d expected 0,1,0,1", na, ga[0], ga[1], ga[2], ga[3]);
      end
      n_chk++;
      if (nb != 4 || gb[0] != 0 || gb[1] != 0 || gb[2] != 0 || gb[3] != 0) begin
         n_fail++;
         $display("FAIL fixed_order: got n=%0d %0d,%0d,%0d,%0d expected 0,0,0,0", nb, gb[0], gb[1], gb[2], gb[3]);
      end
   endtask

   task automatic test_r0_protect();
      int w, s0;
      apply_reset();
      s0 = n_strobe;
      issue(0, 1, 5'd0, 5'd0, 32'h12345678, w);
      n_chk++;
      if ({Bank_signal_write, Busy} !== 2'b01) begin
         n_fail++; $display("FAIL r0_strobe: got we=%b busy=%b expected we=0 busy=1", Bank_signal_write, Busy);
      end
      step();
      n_chk++;
      if (Drop_count !== 8'd1) begin n_fail++; $display("FAIL r0_drop1: got %0d expected 1", Drop_count); end
      issue(1, 0, 5'd0, 5'd0, 32'h0, w);
      step();
      n_chk++;
      if ({Rsp_valid_1, Rsp_valid_0, Rsp_data_1} !== {1'b1, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL r0_read: got v1=%b v0=%b d1=%h expected v1=1 v0=0 d1=0", Rsp_valid_1, Rsp_valid_0, Rsp_data_1);
      end
      step();
      for (int i = 0; i < 255; i++) begin
         issue(0, 1, 5'd0, 5'd0, 32'h12345678, w);
         step();
      end
      n_chk++;
      if (Drop_count !== 8'd255) begin n_fail++; $display("FAIL r0_saturate: got %0d expected 255", Drop_count); end
      n_chk++;
      if (n_strobe - s0 !== 0) begin n_fail++; $display("FAIL r0_no_strobe: got %0d expected 0", n_strobe - s0); end
   endtask

   task automatic test_reset_mid_read();
      int w, r0;
      apply_reset();
      issue(0, 0, 5'd5, 5'd5, 32'h0, w);
      n_chk++;
      if (Busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b expected 1", Busy); end
      r0 = n_rsp;
      #2;
      Signal_reset = 1;
      #1;
      n_chk++;
      if ({Busy, Bank_signal_write, Rsp_valid_0, Bank_read_1, Bank_read_2, Rsp_data_1, Drop_count} !== '0) begin
         n_fail++;
         $display("FAIL mid_async: got busy=%b we=%b v0=%b r1=%0d r2=%0d d1=%h drop=%0d expected all 0",
                  Busy, Bank_signal_write, Rsp_valid_0, Bank_read_1, Bank_read_2, Rsp_data_1, Drop_count);
      end
      step(); step();
      Signal_reset = 0;
      step(); step();
      n_chk++;
      if (n_rsp - r0 !== 0) begin n_fail++; $display("FAIL mid_no_rsp: got %0d pulses expected 0", n_rsp - r0); end
      issue(1, 1, 5'd9, 5'd0, 32'h00C0FFEE, w);
      n_chk++;
      if (w !== 0) begin n_fail++; $display("FAIL mid_first_accept: got wait %0d expected 0", w); end
      n_chk++;
      if ({Bank_signal_write, Bank_address_to_write} !== {1'b1, 5'd9}) begin
         n_fail++; $display("FAIL mid_post_write: got we=%b a=%0d expected we=1 a=9", Bank_signal_write, Bank_address_to_write);
      end
      step();
   endtask

   task automatic test_back_to_back();
      apply_reset();
      Req_write_0 = 0; Req_addr_a_0 = 5'd5; Req_addr_b_0 = 5'd9;
      Req_write_1 = 1; Req_addr_a_1 = 5'd10; Req_data_1 = 32'hA5A5A5A5;
      Req_valid_0 = 1; Req_valid_1 = 1;
      #1;
      n_chk++;
      if ({Req_ready_0, Req_ready_1} !== 2'b10) begin
         n_fail++; $display("FAIL b2b_accept: got r0=%b r1=%b expected r0=1 r1=0", Req_ready_0, Req_ready_1);
      end
      step();
      Req_valid_0 = 0;
      n_chk++;
      if ({Req_ready_1, Busy} !== 2'b01) begin
         n_fail++; $display("FAIL b2b_issue: got r1=%b busy=%b expected r1=0 busy=1", Req_ready_1, Busy);
      end
      step();
      n_chk++;
      if ({Req_ready_1, Rsp_valid_0, Rsp_data_1, Rsp_data_2} !== {1'b0, 1'b1, 32'hDEADBEEF, 32'h00C0FFEE}) begin
         n_fail++;
         $display("FAIL b2b_resp: got r1=%b v0=%b d1=%h d2=%h expected r1=0 v0=1 d1=deadbeef d2=00c0ffee",
                  Req_ready_1, Rsp_valid_0, Rsp_data_1, Rsp_data_2);
      end
      step();
      n_chk++;
      if ({Req_ready_1, Busy} !== 2'b10) begin
         n_fail++; $display("FAIL b2b_idle_grant: got r1=%b busy=%b expected r1=1 busy=0", Req_ready_1, Busy);
      end
      step();
      Req_valid_1 = 0;
      n_chk++;
      if ({Bank_signal_write, Bank_address_to_write, Bank_data_to_write} !== {1'b1, 5'd10, 32'hA5A5A5A5}) begin
         n_fail++;
         $display("FAIL b2b_write: got we=%b a=%0d d=%h expected we=1 a=10 d=a5a5a5a5",
                  Bank_signal_write, Bank_address_to_write, Bank_data_to_write);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_contention();
      test_r0_protect();
      test_reset_mid_read();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
